serial_cmp_ctrl: RTL

Multi-cycle unsigned magnitude-compare controller for the branch/compare path.
- Walks two WIDTH-bit operands MSB-first, 2 bits per cycle, through one shared 2-bit compare slice.
- Carries EQ/GT state between cycles in a chain, so one small slice serves a full-width compare.
- Sits beside the ALU; the branch-resolve stage issues start/operands and consumes eq/gt/lt on done.

---
 rtl/serial_cmp_pkg.sv | 15 +
 rtl/cmp_slice_2.sv | 26 ++
 rtl/serial_cmp_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the serial magnitude-compare controller.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned SLICE_W = 2;

    localparam logic EQ_INIT = 1'b1;
    localparam logic GT_INIT = 1'b0;

endpackage

// File: rtl/cmp_slice_2.sv
// Combinational 2-bit compare slice; folds the local compare into the running EQ/GT chain.
module cmp_slice_2
    import serial_cmp_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               eq_prev,
    input  logic               gt_prev,
    output logic               eq,
    output logic               gt
);

    logic slice_eq;
    logic slice_gt;
    logic undecided;

    always_comb begin
        slice_eq  = (a == b);
        slice_gt  = (a > b);
        undecided = eq_prev & ~gt_prev;
        eq        = undecided & slice_eq;
        // Once a higher slice has decided, its verdict sticks.
        gt        = (undecided & slice_gt) | (~eq_prev & gt_prev);
    end

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Multi-cycle unsigned compare walking operands MSB-first, 2 bits per cycle.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish as soon as the outcome is decided.
module serial_cmp_ctrl
    import serial_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH / 2)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam logic [CNT_W-1:0] IdxInit = CNT_W'(WIDTH / 2 - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             eq_r_q, eq_r_d, gt_r_q, gt_r_d;
    logic             done_q, done_d;
    logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;

    logic [SLICE_W-1:0] sl_a, sl_b;
    logic               sl_eq, sl_gt;
    logic               finish;

    always_comb begin
        sl_a = a_q[{idx_q, 1'b0} +: SLICE_W];
        sl_b = b_q[{idx_q, 1'b0} +: SLICE_W];
    end

    cmp_slice_2 u_slice (
        .a       (sl_a),
        .b       (sl_b),
        .eq_prev (eq_r_q),
        .gt_prev (gt_r_q),
        .eq      (sl_eq),
        .gt      (sl_gt)
    );

    always_comb begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        // Decided as soon as the chain leaves the undecided (eq=1, gt=0) state.
        finish = (idx_q == '0) | sl_gt | ~sl_eq;
`else
        finish = (idx_q == '0);
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        eq_r_d  = eq_r_q;
        gt_r_d  = gt_r_q;
        done_d  = 1'b0;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    eq_r_d  = EQ_INIT;
                    gt_r_d  = GT_INIT;
                    idx_d   = IdxInit;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                eq_r_d = sl_eq;
                gt_r_d = sl_gt;
                if (finish) begin
                    eq_d    = sl_eq;
                    gt_d    = sl_gt;
                    lt_d    = ~sl_eq & ~sl_gt;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            eq_r_q  <= EQ_INIT;
            gt_r_q  <= GT_INIT;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            eq_r_q  <= eq_r_d;
            gt_r_q  <= gt_r_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    // Operand registers are deliberately left out of reset.
    always_ff @(posedge clock) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    always_comb begin
        ready = (state_q != StRun);
        busy  = (state_q == StRun);
        done  = done_q;
        eq    = eq_q;
        gt    = gt_q;
        lt    = lt_q;
    end

endmodule
